// File: rtl/regfile_wb_queue.sv
// In-order write-back queue feeding the register bank, with a forwarding
// lookup over queued writes and a sticky illegal-address flag.
module regfile_wb_queue #(
  parameter int NREGS  = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4,
  parameter int DATA_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              wb_hold,
  output logic [NREGS-1:0]  chosen,
  output logic              w_en,
  output logic [DATA_W-1:0] w_data,
  input  logic [ADDR_W-1:0] fwd_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] NREGS_L = (ADDR_W+1)'(NREGS);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [ADDR_W:0]   count_reg;
  logic              err_reg;

  logic              addr_legal;
  logic              push;
  logic              pop;
  logic              bad_req;
  logic [ADDR_W-1:0] head_addr;
  logic [DEPTH-1:0]  entry_match;

  assign full     = (count_reg == DEPTH_L);
  assign empty    = (count_reg == '0);
  assign in_ready = !full;
  assign count    = count_reg;
  assign err      = err_reg;

  assign addr_legal = ({1'b0, in_addr} < NREGS_L);
  assign push       = in_valid & in_ready & addr_legal;
  assign bad_req    = in_valid & in_ready & !addr_legal;

  assign w_en      = !empty & !wb_hold;
  assign pop       = w_en;
  assign head_addr = addr_mem[rd_ptr_reg];
  assign w_data    = w_en ? data_mem[rd_ptr_reg] : '0;

  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_chosen
      assign chosen[gi] = w_en && (head_addr == ADDR_W'(gi));
    end
  endgenerate

  // An entry is live when its distance from the head is below count.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      logic [PTR_W-1:0] entry_off;
      assign entry_off       = PTR_W'(gi) - rd_ptr_reg;
      assign entry_match[gi] = ((ADDR_W+1)'(entry_off) < count_reg) &&
                               (addr_mem[gi] == fwd_addr);
    end
  endgenerate

  // Walk oldest to youngest so the youngest match overwrites earlier ones.
  always_comb begin
    logic [PTR_W-1:0] idx;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_reg + PTR_W'(k);
      if (entry_match[idx]) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_reg] <= in_addr;
      data_mem[wr_ptr_reg] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      err_reg    <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (bad_req) err_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue with NREGS=6 so that addresses 6 and 7 are illegal.
module tb_regfile_wb_queue;

  localparam int NREGS  = 6;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 7;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              wb_hold;
  logic [NREGS-1:0]  chosen;
  logic              w_en;
  logic [DATA_W-1:0] w_data;
  logic [ADDR_W-1:0] fwd_addr;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              err;

  int tests = 0;
  int fails = 0;

  regfile_wb_queue #(.NREGS(NREGS), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .wb_hold(wb_hold), .chosen(chosen),
    .w_en(w_en), .w_data(w_data), .fwd_addr(fwd_addr), .fwd_hit(fwd_hit),
    .fwd_data(fwd_data), .count(count), .full(full), .empty(empty), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic push_one(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    in_valid = 1'b1; in_addr = a; in_data = d;
    step();
    in_valid = 1'b0;
    #1;
    $display("[TB] push addr=%0d data=%h count=%0d err=%0b", a, d, count, err);
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (count !== 4'd0)   begin fails++; $display("FAIL reset_count got=%0d exp=0", count); end
    tests++; if (empty !== 1'b1)   begin fails++; $display("FAIL reset_empty got=%b exp=1", empty); end
    tests++; if (full !== 1'b0)    begin fails++; $display("FAIL reset_full got=%b exp=0", full); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    tests++; if ({w_en, chosen, w_data} !== '0) begin fails++; $display("FAIL reset_drain w_en=%b chosen=%b w_data=%h exp=0", w_en, chosen, w_data); end
    tests++; if ({fwd_hit, fwd_data} !== '0) begin fails++; $display("FAIL reset_fwd hit=%b data=%h exp=0", fwd_hit, fwd_data); end
    tests++; if (err !== 1'b0)     begin fails++; $display("FAIL reset_err got=%b exp=0", err); end
  endtask

  task automatic test_single_write();
    push_one(3'd2, 7'h55);
    tests++; if (w_en !== 1'b1)          begin fails++; $display("FAIL single_w_en got=%b exp=1", w_en); end
    tests++; if (chosen !== 6'b000100)   begin fails++; $display("FAIL single_chosen got=%b exp=000100", chosen); end
    tests++; if (w_data !== 7'h55)       begin fails++; $display("FAIL single_w_data got=%h exp=55", w_data); end
    step();
    $display("[TB] retire addr=2 data=55");
    tests++; if (empty !== 1'b1)         begin fails++; $display("FAIL single_empty got=%b exp=1", empty); end
    tests++; if ({w_en, chosen} !== '0)  begin fails++; $display("FAIL single_idle w_en=%b chosen=%b exp=0", w_en, chosen); end
  endtask

  task automatic test_fill_and_drain();
    logic [NREGS-1:0] exp_ch;
    wb_hold = 1'b1;
    for (int i = 0; i < 4; i++) push_one(ADDR_W'(i), DATA_W'(8'h10 + i));
    tests++; if (count !== 4'd4)   begin fails++; $display("FAIL fill_count got=%0d exp=4", count); end
    tests++; if (full !== 1'b1)    begin fails++; $display("FAIL fill_full got=%b exp=1", full); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
    tests++; if (w_en !== 1'b0)    begin fails++; $display("FAIL fill_hold_w_en got=%b exp=0", w_en); end
    push_one(3'd4, 7'h7F);
    tests++; if (count !== 4'd4)   begin fails++; $display("FAIL fill_reject_count got=%0d exp=4", count); end
    wb_hold = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_ch = NREGS'(1) << i;
      tests++; if (w_en !== 1'b1 || chosen !== exp_ch || w_data !== DATA_W'(8'h10 + i))
        begin fails++; $display("FAIL drain_%0d w_en=%b chosen=%b w_data=%h exp w_en=1 chosen=%b w_data=%h", i, w_en, chosen, w_data, exp_ch, DATA_W'(8'h10 + i)); end
      step();
      $display("[TB] retire #%0d", i);
    end
    tests++; if (empty !== 1'b1)   begin fails++; $display("FAIL drain_empty got=%b exp=1", empty); end
  endtask

  task automatic test_forwarding();
    wb_hold = 1'b1;
    push_one(3'd5, 7'h21);
    push_one(3'd5, 7'h3A);
    fwd_addr = 3'd5; #1;
    tests++; if (fwd_hit !== 1'b1 || fwd_data !== 7'h3A) begin fails++; $display("FAIL fwd_hit5 hit=%b data=%h exp hit=1 data=3a", fwd_hit, fwd_data); end
    fwd_addr = 3'd6; #1;
    tests++; if (fwd_hit !== 1'b0 || fwd_data !== 7'h00) begin fails++; $display("FAIL fwd_miss6 hit=%b data=%h exp hit=0 data=00", fwd_hit, fwd_data); end
    wb_hold = 1'b0;
    fwd_addr = 3'd5; #1;
    tests++; if (fwd_hit !== 1'b1 || fwd_data !== 7'h3A) begin fails++; $display("FAIL fwd_retiring hit=%b data=%h exp hit=1 data=3a", fwd_hit, fwd_data); end
    step(); step();
    tests++; if (empty !== 1'b1 || fwd_hit !== 1'b0) begin fails++; $display("FAIL fwd_after_drain empty=%b hit=%b exp empty=1 hit=0", empty, fwd_hit); end
  endtask

  task automatic test_back_to_back();
    wb_hold = 1'b1;
    for (int i = 0; i < 4; i++) push_one(ADDR_W'(i), DATA_W'(8'h20 + i));
    wb_hold = 1'b0;
    in_valid = 1'b1; in_addr = 3'd1; in_data = 7'h44;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b_full_ready got=%b exp=0", in_ready); end
    step();
    tests++; if (count !== 4'd3)    begin fails++; $display("FAIL b2b_pop_only count=%0d exp=3", count); end
    step();
    in_valid = 1'b0;
    #1;
    $display("[TB] push addr=1 data=44 alongside pop");
    tests++; if (count !== 4'd3)    begin fails++; $display("FAIL b2b_push_pop count=%0d exp=3", count); end
    fwd_addr = 3'd1; #1;
    tests++; if (fwd_hit !== 1'b1 || fwd_data !== 7'h44) begin fails++; $display("FAIL b2b_fwd hit=%b data=%h exp hit=1 data=44", fwd_hit, fwd_data); end
    tests++; if (w_data !== 7'h22) begin fails++; $display("FAIL b2b_head0 got=%h exp=22", w_data); end
    step();
    tests++; if (w_data !== 7'h23) begin fails++; $display("FAIL b2b_head1 got=%h exp=23", w_data); end
    step();
    tests++; if (w_data !== 7'h44 || chosen !== 6'b000010) begin fails++; $display("FAIL b2b_head2 w_data=%h chosen=%b exp 44/000010", w_data, chosen); end
    step();
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL b2b_empty got=%b exp=1", empty); end
  endtask

  task automatic test_illegal_addr();
    wb_hold = 1'b0;
    push_one(3'd7, 7'h11);
    tests++; if (count !== 4'd0 || err !== 1'b1) begin fails++; $display("FAIL illegal_drop count=%0d err=%b exp count=0 err=1", count, err); end
    tests++; if (in_ready !== 1'b1 || w_en !== 1'b0) begin fails++; $display("FAIL illegal_ready in_ready=%b w_en=%b exp 1/0", in_ready, w_en); end
    for (int i = 0; i < 10; i++) begin
      push_one(ADDR_W'(i % NREGS), DATA_W'(i));
      tests++; if (err !== 1'b1) begin fails++; $display("FAIL illegal_sticky_%0d err=%b exp=1", i, err); end
    end
    step();
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL illegal_drained empty=%b exp=1", empty); end
  endtask

  task automatic test_reset_priority();
    wb_hold = 1'b1;
    for (int i = 0; i < 3; i++) push_one(ADDR_W'(i), DATA_W'(8'h30 + i));
    tests++; if (count !== 4'd3 || err !== 1'b1) begin fails++; $display("FAIL rstp_pre count=%0d err=%b exp 3/1", count, err); end
    in_valid = 1'b1; in_addr = 3'd4; in_data = 7'h4C;
    rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0; wb_hold = 1'b0;
    #1;
    $display("[TB] reset with pending push");
    tests++; if (count !== 4'd0 || empty !== 1'b1) begin fails++; $display("FAIL rstp_count count=%0d empty=%b exp 0/1", count, empty); end
    tests++; if (w_en !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL rstp_flags w_en=%b err=%b exp 0/0", w_en, err); end
    fwd_addr = 3'd4; #1;
    tests++; if (fwd_hit !== 1'b0) begin fails++; $display("FAIL rstp_fwd hit=%b exp=0", fwd_hit); end
    step();
    tests++; if (count !== 4'd0 || w_en !== 1'b0) begin fails++; $display("FAIL rstp_not_stored count=%0d w_en=%b exp 0/0", count, w_en); end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
    wb_hold = 1'b0; fwd_addr = '0;
    test_reset();
    test_single_write();
    test_fill_and_drain();
    test_forwarding();
    test_back_to_back();
    test_illegal_addr();
    test_reset_priority();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
- Write-back buffer placed directly upstream of the 7-bit register bank.
- Accepts register-write requests (address + 7-bit data) from the execute stage and queues them in order.
- Drains one write per cycle into the bank by driving the bank's shared w_en and w_data plus a one-hot chosen vector.
- Provides a forwarding lookup, so readers see queued writes before they retire, and a sticky error flag for illegal addresses.

Parameters:
- NREGS, 8: number of registers in the bank; width of the chosen vector.
- ADDR_W, 3: address width; must satisfy 2**ADDR_W >= NREGS.
- DEPTH, 4: queue entries; power of two, at least 2.
- DATA_W, 7: data width; matches the bank register width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  a write request is present.
- in_ready  out  1  queue can accept a request; equals !full.
- in_addr  in  ADDR_W  target register index.
- in_data  in  DATA_W  write data.
- wb_hold  in  1  stalls draining when high.
- chosen  out  NREGS  one-hot register select; all zeros when w_en=0.
- w_en  out  1  bank write enable for this cycle.
- w_data  out  DATA_W  data for the bank write.
- fwd_addr  in  ADDR_W  forwarding lookup address.
- fwd_hit  out  1  a queued entry targets fwd_addr.
- fwd_data  out  DATA_W  data of the youngest matching entry; 0 when no hit.
- count  out  ADDR_W+1  number of occupied entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- err  out  1  sticky: an illegal address was presented.

Behaviour:
- Storage: circular buffer with wr_ptr, rd_ptr and count. Pointers wrap modulo DEPTH.
- Reset: when rst=1 at a clock edge, pointers, count and err all clear to 0. Entry contents are don't-care. rst has priority over every other event, including a simultaneous push or pop.
- After reset: empty=1, full=0, in_ready=1, w_en=0, chosen=0, w_data=0, fwd_hit=0, fwd_data=0, count=0.
- Push: occurs when in_valid & in_ready & (in_addr < NREGS). The entry is written at wr_ptr, wr_ptr increments, and the entry becomes visible the next cycle.
- Illegal address: in_valid & in_ready & (in_addr >= NREGS) drops the request and sets err=1. err stays set until reset. in_ready is not affected.
- Drain (combinational from head):
  - w_en = !empty & !wb_hold.
  - w_data = head data when w_en=1, else 0.
  - chosen = one-hot(head addr) when w_en=1, else 0.
  - When w_en=1 at a clock edge, the bank captures the write, rd_ptr increments and the entry leaves the queue. Latency from accepted push to bank write is at least 1 cycle.
- Simultaneous push and pop: count is unchanged and both pointers advance. While full, in_ready=0 even if a pop happens that cycle; the request is accepted the following cycle.
- Hold: wb_hold=1 freezes rd_ptr; pushes still proceed until full.
- Ordering: strict FIFO. Multiple entries to the same address all retire in order, so the last write wins in the bank.
- Forwarding: combinational search over valid entries only, including the head entry that is retiring this cycle.
  - fwd_hit=1 if any entry's addr equals fwd_addr.
  - fwd_data comes from the youngest matching entry, closest to wr_ptr.
  - A request being pushed in the same cycle is not visible to forwarding.
- count is always in the range 0..DEPTH; full and empty are derived from count.

Test Plan:
1. Reset, then push (addr=2, data=7'h55) with wb_hold=0 -> next cycle w_en=1, chosen=8'b0000_0100, w_data=7'h55; the following cycle empty=1, w_en=0, chosen=0.
2. wb_hold=1; push addr 0,1,2,3 with data 7'h10..7'h13 -> count=4, full=1, in_ready=0; a 5th push (addr 4, data 7'h7F) is not accepted. Release hold -> four writes retire in order on consecutive cycles, chosen = 01,02,04,08 (hex).
3. wb_hold=1; push (5, 7'h21) then (5, 7'h3A); set fwd_addr=5 -> fwd_hit=1, fwd_data=7'h3A. fwd_addr=6 -> fwd_hit=0, fwd_data=0.
4. Queue full with wb_hold=0 and in_valid held for 2 cycles -> in the first cycle a pop occurs with no push (count 4->3); in the second cycle a push and a pop occur together (count stays 3, both pointers advance).
5. With NREGS=6 and ADDR_W=3, push addr=7 -> entry dropped, count unchanged, err=1. err remains 1 through 10 further valid pushes and clears only on rst.
6. rst asserted for one cycle while count=3 and a push is pending -> next cycle count=0, empty=1, w_en=0, err=0, and the pending push is not stored.
